// File: rtl/spi_target_pkg.sv
// Shared constants and types for the SPI target block.
package spi_target_pkg;

    localparam int SPI_FRAME_BITS = 8;
    localparam logic [SPI_FRAME_BITS-1:0] SPI_TX_IDLE_BYTE = 8'h00;
    localparam int BIT_CNT_W = $clog2(SPI_FRAME_BITS);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_target_if.sv
// SPI pin bundle plus the local byte-side handshake of the SPI target.
interface spi_target_if;
    import spi_target_pkg::*;

    logic                      sck;
    logic                      ss_n;
    logic                      mosi;
    logic                      miso;
    logic                      miso_oe;
    logic [SPI_FRAME_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic [SPI_FRAME_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic                      busy;
    logic                      underrun;
    logic                      underrun_clr;

    modport slave (
        input  sck, ss_n, mosi, tx_data, tx_valid, underrun_clr,
        output miso, miso_oe, rx_data, rx_valid, tx_ready, busy, underrun
    );

    modport master (
        output sck, ss_n, mosi, tx_data, tx_valid, underrun_clr,
        input  miso, miso_oe, rx_data, rx_valid, tx_ready, busy, underrun
    );

endinterface

// File: rtl/spi_target_synchronizer.sv
// Single-bit flop-chain synchronizer with configurable depth and reset value.
module synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronized pins, byte shift registers, one-deep TX buffer.
// state     | meaning
// ST_IDLE   | target not selected, waiting for ss_n low
// ST_ACTIVE | selected, shifting on synchronized sck edges
module spi_target
    import spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         rst_n,
    spi_target_if.slave bus
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SPI_FRAME_BITS - 1);

    logic sck_s, ss_n_s, mosi_s, sck_q;
    logic rise, fall;

    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d(bus.sck), .q(sck_s)
    );
    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
        .clk(clk), .rst_n(rst_n), .d(bus.ss_n), .q(ss_n_s)
    );
    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(bus.mosi), .q(mosi_s)
    );

    assign rise = sck_s & ~sck_q;
    assign fall = ~sck_s & sck_q;

    spi_state_e state_q, state_d;
    logic       enter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ss_n_s) begin
                    state_d = ST_ACTIVE;
                    enter   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_n_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [SPI_FRAME_BITS-1:0] rx_shift, tx_shift, tx_buf, rx_data_q;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic                      buf_full, buf_full_d, tx_ready_q;
    logic                      rx_valid_q, underrun_q;
    logic                      active, abort, shift_rise, shift_fall;
    logic                      load_tx, accept;

    // A deselect always outranks any sck edge seen in the same cycle.
    assign active     = (state_q == ST_ACTIVE) && !ss_n_s;
    assign abort      = (state_q == ST_ACTIVE) && ss_n_s;
    assign shift_rise = active && rise;
    assign shift_fall = active && fall;
    assign load_tx    = enter || (shift_fall && (bit_cnt == '0));
    assign accept     = bus.tx_valid && tx_ready_q;

    always_comb begin
        buf_full_d = buf_full;
        if (load_tx) buf_full_d = 1'b0;
        if (accept)  buf_full_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q      <= 1'b0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_buf     <= '0;
            bit_cnt    <= '0;
            buf_full   <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            sck_q      <= sck_s;
            buf_full   <= buf_full_d;
            tx_ready_q <= ~buf_full_d;
            rx_valid_q <= 1'b0;

            if (accept) tx_buf <= bus.tx_data;

            if (load_tx) begin
                tx_shift <= buf_full ? tx_buf : SPI_TX_IDLE_BYTE;
            end else if (shift_fall) begin
                tx_shift <= {tx_shift[SPI_FRAME_BITS-2:0], 1'b0};
            end else if (abort) begin
                tx_shift <= '0;
            end

            if (enter || abort) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (shift_rise) begin
                bit_cnt  <= bit_cnt + 1'b1;
                rx_shift <= {rx_shift[SPI_FRAME_BITS-2:0], mosi_s};
                if (bit_cnt == LAST_BIT) begin
                    rx_data_q  <= {rx_shift[SPI_FRAME_BITS-2:0], mosi_s};
                    rx_valid_q <= 1'b1;
                end
            end

            if (load_tx && !buf_full) begin
                underrun_q <= 1'b1;
            end else if (bus.underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign bus.miso     = tx_shift[SPI_FRAME_BITS-1];
    assign bus.miso_oe  = ~ss_n_s;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = (state_q == ST_ACTIVE);
    assign bus.underrun = underrun_q;

endmodule
